// File: rtl/int_rsv_station.sv
// Integer reservation station.
// Holds dispatched integer ops until both operands are available. Operands
// are captured from the CDB as results are broadcast, and the lowest-index
// ready entry is moved into an output register that drives the integer unit.
module int_rsv_station #(
    parameter int BW_PROCESSOR_DATA = 32,
    parameter int BW_OPCODE_INT     = 4,
    parameter int BW_TAG            = 3,
    parameter int N_ENTRY           = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           i_dsp_valid,
    output logic                           o_dsp_ready,
    input  logic [BW_OPCODE_INT-1:0]       i_dsp_opcode,
    input  logic [BW_TAG-1:0]              i_dsp_tag,
    input  logic [1:0]                     i_dsp_busy,
    input  logic [2*BW_TAG-1:0]            i_dsp_Q_flatten,
    input  logic [2*BW_PROCESSOR_DATA-1:0] i_dsp_V_flatten,
    input  logic                           i_cdb_valid,
    input  logic [BW_TAG-1:0]              i_cdb_tag,
    input  logic [BW_PROCESSOR_DATA-1:0]   i_cdb_wdata,
    output logic                           o_iu_valid,
    input  logic                           i_iu_ready,
    output logic [BW_OPCODE_INT-1:0]       o_iu_opcode,
    output logic [BW_TAG-1:0]              o_iu_tag,
    output logic [2*BW_PROCESSOR_DATA-1:0] o_iu_V_flatten,
    output logic [$clog2(N_ENTRY+1)-1:0]   o_count
);

    localparam int BW_IDX = (N_ENTRY > 1) ? $clog2(N_ENTRY) : 1;
    localparam int BW_CNT = $clog2(N_ENTRY+1);

    logic [N_ENTRY-1:0]           ent_valid;
    logic [BW_OPCODE_INT-1:0]     ent_opcode [N_ENTRY];
    logic [BW_TAG-1:0]            ent_tag    [N_ENTRY];
    logic [1:0]                   ent_busy   [N_ENTRY];
    logic [BW_TAG-1:0]            ent_q      [N_ENTRY][2];
    logic [BW_PROCESSOR_DATA-1:0] ent_v      [N_ENTRY][2];

    logic                         orv;
    logic                         free_found;
    logic [BW_IDX-1:0]            free_idx;
    logic                         rdy_found;
    logic [BW_IDX-1:0]            rdy_idx;
    logic [BW_CNT-1:0]            cnt;
    logic                         dsp_fire;
    logic                         load;
    logic [1:0]                   dsp_busy_eff;
    logic [BW_PROCESSOR_DATA-1:0] dsp_v_eff [2];

    // Priority pick of the lowest free slot and the lowest ready entry.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        rdy_found  = 1'b0;
        rdy_idx    = '0;
        for (int i = N_ENTRY - 1; i >= 0; i--) begin
            if (!ent_valid[i]) begin
                free_found = 1'b1;
                free_idx   = BW_IDX'(i);
            end
            if (ent_valid[i] && (ent_busy[i] == 2'b00)) begin
                rdy_found = 1'b1;
                rdy_idx   = BW_IDX'(i);
            end
        end
    end

    // Occupancy count from the registered valid bits.
    always_comb begin
        cnt = '0;
        for (int i = 0; i < N_ENTRY; i++) begin
            cnt = cnt + BW_CNT'(ent_valid[i]);
        end
    end

    // Dispatch operands, bypassing a CDB result broadcast in the same cycle.
    always_comb begin
        dsp_busy_eff = i_dsp_busy;
        for (int k = 0; k < 2; k++) begin
            dsp_v_eff[k] = i_dsp_V_flatten[k*BW_PROCESSOR_DATA +: BW_PROCESSOR_DATA];
            if (i_dsp_busy[k] && i_cdb_valid &&
                (i_dsp_Q_flatten[k*BW_TAG +: BW_TAG] == i_cdb_tag)) begin
                dsp_busy_eff[k] = 1'b0;
                dsp_v_eff[k]    = i_cdb_wdata;
            end
        end
    end

    assign o_dsp_ready = free_found;
    assign dsp_fire    = i_dsp_valid && free_found;
    assign load        = (!orv || i_iu_ready) && rdy_found;
    assign o_count     = cnt;
    assign o_iu_valid  = orv;

    // Entry storage: CDB wake-up, invalidate on load, fill on dispatch.
    // The dispatch slot is invalid and the load slot is valid, so they never collide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_valid <= '0;
            for (int i = 0; i < N_ENTRY; i++) begin
                ent_opcode[i] <= '0;
                ent_tag[i]    <= '0;
                ent_busy[i]   <= '0;
                for (int k = 0; k < 2; k++) begin
                    ent_q[i][k] <= '0;
                    ent_v[i][k] <= '0;
                end
            end
        end else begin
            for (int i = 0; i < N_ENTRY; i++) begin
                for (int k = 0; k < 2; k++) begin
                    if (ent_valid[i] && ent_busy[i][k] && i_cdb_valid &&
                        (ent_q[i][k] == i_cdb_tag)) begin
                        ent_busy[i][k] <= 1'b0;
                        ent_v[i][k]    <= i_cdb_wdata;
                    end
                end
            end
            if (load) begin
                ent_valid[rdy_idx] <= 1'b0;
            end
            if (dsp_fire) begin
                ent_valid[free_idx]  <= 1'b1;
                ent_opcode[free_idx] <= i_dsp_opcode;
                ent_tag[free_idx]    <= i_dsp_tag;
                ent_busy[free_idx]   <= dsp_busy_eff;
                for (int k = 0; k < 2; k++) begin
                    ent_q[free_idx][k] <= i_dsp_Q_flatten[k*BW_TAG +: BW_TAG];
                    ent_v[free_idx][k] <= dsp_v_eff[k];
                end
            end
        end
    end

    // Output register toward the integer unit; holds while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            orv            <= 1'b0;
            o_iu_opcode    <= '0;
            o_iu_tag       <= '0;
            o_iu_V_flatten <= '0;
        end else if (load) begin
            orv            <= 1'b1;
            o_iu_opcode    <= ent_opcode[rdy_idx];
            o_iu_tag       <= ent_tag[rdy_idx];
            o_iu_V_flatten <= {ent_v[rdy_idx][1], ent_v[rdy_idx][0]};
        end else if (orv && i_iu_ready) begin
            orv <= 1'b0;
        end
    end

endmodule

// File: tb/tb_int_rsv_station.sv
// Testbench for int_rsv_station: directed vector table, hand sequences for
// full/stall/order/reset corners, and random traffic against a reference model.
module tb_int_rsv_station;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_dsp_valid = 1'b0;
    logic        o_dsp_ready;
    logic [3:0]  i_dsp_opcode = '0;
    logic [2:0]  i_dsp_tag = '0;
    logic [1:0]  i_dsp_busy = '0;
    logic [5:0]  i_dsp_Q_flatten = '0;
    logic [63:0] i_dsp_V_flatten = '0;
    logic        i_cdb_valid = 1'b0;
    logic [2:0]  i_cdb_tag = '0;
    logic [31:0] i_cdb_wdata = '0;
    logic        o_iu_valid;
    logic        i_iu_ready = 1'b0;
    logic [3:0]  o_iu_opcode;
    logic [2:0]  o_iu_tag;
    logic [63:0] o_iu_V_flatten;
    logic [2:0]  o_count;

    int n_tests = 0;
    int n_fail  = 0;

    int_rsv_station #(
        .BW_PROCESSOR_DATA(32), .BW_OPCODE_INT(4), .BW_TAG(3), .N_ENTRY(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .i_dsp_valid(i_dsp_valid), .o_dsp_ready(o_dsp_ready),
        .i_dsp_opcode(i_dsp_opcode), .i_dsp_tag(i_dsp_tag),
        .i_dsp_busy(i_dsp_busy), .i_dsp_Q_flatten(i_dsp_Q_flatten),
        .i_dsp_V_flatten(i_dsp_V_flatten),
        .i_cdb_valid(i_cdb_valid), .i_cdb_tag(i_cdb_tag), .i_cdb_wdata(i_cdb_wdata),
        .o_iu_valid(o_iu_valid), .i_iu_ready(i_iu_ready),
        .o_iu_opcode(o_iu_opcode), .o_iu_tag(o_iu_tag),
        .o_iu_V_flatten(o_iu_V_flatten), .o_count(o_count)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct packed {
        logic        v;
        logic [3:0]  op;
        logic [2:0]  tag;
        logic [1:0]  busy;
        logic [5:0]  q;
        logic [63:0] d;
    } ent_t;

    ent_t        m_e [4];
    logic        m_orv;
    logic [3:0]  m_op;
    logic [2:0]  m_tag;
    logic [63:0] m_vf;

    function automatic int m_count();
        int c = 0;
        foreach (m_e[i]) if (m_e[i].v) c++;
        return c;
    endfunction

    task automatic model_reset();
        foreach (m_e[i]) m_e[i] = '0;
        m_orv = 0; m_op = '0; m_tag = '0; m_vf = '0;
    endtask

    // One clock edge of behaviour, from the station's rules on the pre-edge state.
    task automatic model_edge();
        ent_t nx [4];
        ent_t ne;
        int   ld = -1;
        int   fr = -1;
        foreach (m_e[i]) nx[i] = m_e[i];
        foreach (m_e[i]) begin
            if (ld < 0 && m_e[i].v && m_e[i].busy == 2'b00) ld = i;
            if (fr < 0 && !m_e[i].v) fr = i;
        end
        if (i_cdb_valid)
            foreach (m_e[i])
                for (int k = 0; k < 2; k++)
                    if (m_e[i].v && m_e[i].busy[k] && m_e[i].q[k*3 +: 3] == i_cdb_tag) begin
                        nx[i].busy[k]     = 1'b0;
                        nx[i].d[k*32 +: 32] = i_cdb_wdata;
                    end
        if ((!m_orv || i_iu_ready) && ld >= 0) begin
            m_orv = 1; m_op = m_e[ld].op; m_tag = m_e[ld].tag; m_vf = m_e[ld].d;
            nx[ld].v = 1'b0;
        end else if (m_orv && i_iu_ready) begin
            m_orv = 0;
        end
        if (i_dsp_valid && fr >= 0) begin
            ne.v = 1; ne.op = i_dsp_opcode; ne.tag = i_dsp_tag;
            ne.busy = i_dsp_busy; ne.q = i_dsp_Q_flatten; ne.d = i_dsp_V_flatten;
            for (int k = 0; k < 2; k++)
                if (i_dsp_busy[k] && i_cdb_valid && i_dsp_Q_flatten[k*3 +: 3] == i_cdb_tag) begin
                    ne.busy[k] = 1'b0;
                    ne.d[k*32 +: 32] = i_cdb_wdata;
                end
            nx[fr] = ne;
        end
        foreach (m_e[i]) m_e[i] = nx[i];
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("model_dsp_ready", 64'(o_dsp_ready), 64'(m_count() < 4));
        chk("model_count",     64'(o_count),     64'(m_count()));
        chk("model_iu_valid",  64'(o_iu_valid),  64'(m_orv));
        chk("model_iu_opcode", 64'(o_iu_opcode), 64'(m_op));
        chk("model_iu_tag",    64'(o_iu_tag),    64'(m_tag));
        chk("model_iu_V",      o_iu_V_flatten,   m_vf);
    endtask

    // Inputs are driven at the falling edge; outputs are checked at the next falling edge.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_model();
    endtask

    task automatic drive(input logic dv, input logic [3:0] op, input logic [2:0] tag,
                         input logic [1:0] busy, input logic [2:0] q0, input logic [2:0] q1,
                         input logic [31:0] v0, input logic [31:0] v1,
                         input logic cv, input logic [2:0] ctag, input logic [31:0] cdata,
                         input logic iur);
        i_dsp_valid = dv; i_dsp_opcode = op; i_dsp_tag = tag; i_dsp_busy = busy;
        i_dsp_Q_flatten = {q1, q0}; i_dsp_V_flatten = {v1, v0};
        i_cdb_valid = cv; i_cdb_tag = ctag; i_cdb_wdata = cdata; i_iu_ready = iur;
    endtask

    task automatic idle(input logic iur);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, iur);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic dv; logic [3:0] op; logic [2:0] tag; logic [1:0] busy;
        logic [2:0] q0; logic [2:0] q1; logic [31:0] v0; logic [31:0] v1;
        logic cv; logic [2:0] ctag; logic [31:0] cdata; logic iur;
        logic e_rdy; logic [2:0] e_cnt; logic e_iuv; logic [3:0] e_op;
        logic [2:0] e_tag; logic [63:0] e_vf;
    } vec_t;

    vec_t vt [12];

    initial begin
        // ADD with ready operands, then CDB bypass at dispatch, then late wake-up + stall
        vt[0]  = '{1,1,2,2'b00,0,0,5,7,      0,0,0,1,       1,1,0,0,0,64'h0};
        vt[1]  = '{0,0,0,2'b00,0,0,0,0,      0,0,0,1,       1,0,1,1,2,{32'd7,32'd5}};
        vt[2]  = '{0,0,0,2'b00,0,0,0,0,      0,0,0,1,       1,0,0,1,2,{32'd7,32'd5}};
        vt[3]  = '{1,2,5,2'b10,0,3,11,0,     1,3,9,1,       1,1,0,1,2,{32'd7,32'd5}};
        vt[4]  = '{0,0,0,2'b00,0,0,0,0,      0,0,0,1,       1,0,1,2,5,{32'd9,32'd11}};
        vt[5]  = '{0,0,0,2'b00,0,0,0,0,      0,0,0,1,       1,0,0,2,5,{32'd9,32'd11}};
        vt[6]  = '{1,3,1,2'b01,4,0,0,32'h22, 0,0,0,1,       1,1,0,2,5,{32'd9,32'd11}};
        vt[7]  = '{0,0,0,2'b00,0,0,0,0,      0,0,0,1,       1,1,0,2,5,{32'd9,32'd11}};
        vt[8]  = '{0,0,0,2'b00,0,0,0,0,      1,4,32'h10,1,  1,1,0,2,5,{32'd9,32'd11}};
        vt[9]  = '{0,0,0,2'b00,0,0,0,0,      0,0,0,1,       1,0,1,3,1,{32'h22,32'h10}};
        vt[10] = '{0,0,0,2'b00,0,0,0,0,      0,0,0,0,       1,0,1,3,1,{32'h22,32'h10}};
        vt[11] = '{0,0,0,2'b00,0,0,0,0,      0,0,0,1,       1,0,0,3,1,{32'h22,32'h10}};

        model_reset();
        #12;
        chk("reset_iu_valid", 64'(o_iu_valid), 64'd0);
        chk("reset_count",    64'(o_count), 64'd0);
        chk("reset_dsp_ready",64'(o_dsp_ready), 64'd1);
        chk("reset_iu_V",     o_iu_V_flatten, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int r = 0; r < 12; r++) begin
            drive(vt[r].dv, vt[r].op, vt[r].tag, vt[r].busy, vt[r].q0, vt[r].q1,
                  vt[r].v0, vt[r].v1, vt[r].cv, vt[r].ctag, vt[r].cdata, vt[r].iur);
            step();
            chk($sformatf("vec%0d_dsp_ready", r), 64'(o_dsp_ready), 64'(vt[r].e_rdy));
            chk($sformatf("vec%0d_count", r),     64'(o_count),     64'(vt[r].e_cnt));
            chk($sformatf("vec%0d_iu_valid", r),  64'(o_iu_valid),  64'(vt[r].e_iuv));
            chk($sformatf("vec%0d_iu_opcode", r), 64'(o_iu_opcode), 64'(vt[r].e_op));
            chk($sformatf("vec%0d_iu_tag", r),    64'(o_iu_tag),    64'(vt[r].e_tag));
            chk($sformatf("vec%0d_iu_V", r),      o_iu_V_flatten,   vt[r].e_vf);
        end

        // Fill with pending entries, overflow dispatch ignored, stall holds outputs.
        for (int i = 0; i < 4; i++) begin
            drive(1, 4'(4 + i), 3'(i), 2'b11, 6, 7, 32'(100 + i), 32'(200 + i), 0, 0, 0, 0);
            step();
        end
        chk("full_dsp_ready", 64'(o_dsp_ready), 64'd0);
        chk("full_count",     64'(o_count), 64'd4);
        drive(1, 4'hf, 3'd4, 2'b00, 0, 0, 1, 2, 0, 0, 0, 0);
        step();
        chk("overflow_count", 64'(o_count), 64'd4);
        chk("overflow_iu_valid", 64'(o_iu_valid), 64'd0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 6, 32'haaaa, 0);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 32'hbbbb, 0);
        step();
        chk("woken_iu_valid", 64'(o_iu_valid), 64'd0);
        idle(0);
        step();
        for (int c = 0; c < 3; c++) begin
            chk("stall_iu_valid", 64'(o_iu_valid), 64'd1);
            chk("stall_iu_tag",   64'(o_iu_tag), 64'd0);
            chk("stall_iu_op",    64'(o_iu_opcode), 64'd4);
            chk("stall_iu_V",     o_iu_V_flatten, {32'hbbbb, 32'haaaa});
            chk("stall_count",    64'(o_count), 64'd3);
            step();
        end
        idle(1);
        for (int t = 1; t < 4; t++) begin
            step();
            chk("drain_order_tag", 64'(o_iu_tag), 64'(t));
            chk("drain_iu_valid",  64'(o_iu_valid), 64'd1);
        end
        step();
        chk("drain_done_iu_valid", 64'(o_iu_valid), 64'd0);

        // Two entries woken by one broadcast issue lowest index first.
        drive(1, 4'h8, 3'd5, 2'b01, 2, 0, 0, 32'h1, 0, 0, 0, 1);
        step();
        drive(1, 4'h9, 3'd6, 2'b01, 2, 0, 0, 32'h2, 0, 0, 0, 1);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 32'h55, 1);
        step();
        idle(1);
        step();
        chk("order_first_tag", 64'(o_iu_tag), 64'd5);
        chk("order_first_V",   o_iu_V_flatten, {32'h1, 32'h55});
        step();
        chk("order_second_tag", 64'(o_iu_tag), 64'd6);
        chk("order_second_V",   o_iu_V_flatten, {32'h2, 32'h55});
        step();

        // Asynchronous reset with ORV set and three valid entries.
        for (int i = 0; i < 4; i++) begin
            drive(1, 4'h3, 3'(i), 2'b00, 0, 0, 32'(i), 32'(i), 0, 0, 0, 0);
            step();
        end
        idle(0);
        chk("pre_reset_count",    64'(o_count), 64'd3);
        chk("pre_reset_iu_valid", 64'(o_iu_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_iu_valid", 64'(o_iu_valid), 64'd0);
        chk("async_rst_count",    64'(o_count), 64'd0);
        chk("async_rst_dsp_ready",64'(o_dsp_ready), 64'd1);
        chk("async_rst_iu_tag",   64'(o_iu_tag), 64'd0);
        chk("async_rst_iu_V",     o_iu_V_flatten, 64'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        for (int c = 0; c < 4; c++) begin
            step();
            chk("post_rst_no_issue", 64'(o_iu_valid), 64'd0);
        end

        // Random traffic against the model.
        for (int c = 0; c < 500; c++) begin
            drive(1'($urandom_range(0, 1)), 4'($urandom), 3'($urandom),
                  2'($urandom), 3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
                  $urandom, $urandom,
                  1'($urandom_range(0, 1)), 3'($urandom_range(0, 3)), $urandom,
                  1'($urandom_range(0, 9) < 7));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/int_rsv_station.md
INT_RSV_STATION -- requirements
Module: int_rsv_station

Interface
REQ-001 SHALL have parameters: BW_PROCESSOR_DATA, 32, operand/result width; BW_OPCODE_INT, 4, integer opcode width; BW_TAG, 3, producer tag width; N_ENTRY, 4, station depth.
REQ-002 SHALL have ports (name  direction  width  meaning):
 clk  in  1  clock
 rst_n  in  1  reset, asynchronous, active-low
 i_dsp_valid  in  1  dispatch request
 o_dsp_ready  out  1  station can accept a dispatch
 i_dsp_opcode  in  BW_OPCODE_INT  integer opcode
 i_dsp_tag  in  BW_TAG  destination tag of instruction
 i_dsp_busy  in  2  bit k=1: operand k pending on tag i_dsp_Q[k]
 i_dsp_Q_flatten  in  2*BW_TAG  producer tags, operand k at [k*BW_TAG +: BW_TAG]
 i_dsp_V_flatten  in  2*BW_PROCESSOR_DATA  operand values, operand k at [k*BW_PROCESSOR_DATA +: BW_PROCESSOR_DATA]
 i_cdb_valid  in  1  CDB broadcast valid
 i_cdb_tag  in  BW_TAG  CDB result tag
 i_cdb_wdata  in  BW_PROCESSOR_DATA  CDB result value
 o_iu_valid  out  1  issue to integer unit valid
 i_iu_ready  in  1  integer unit accepts
 o_iu_opcode  out  BW_OPCODE_INT  issued opcode
 o_iu_tag  out  BW_TAG  issued destination tag
 o_iu_V_flatten  out  2*BW_PROCESSOR_DATA  issued operands, same packing as dispatch
 o_count  out  $clog2(N_ENTRY+1)  occupied entries (excludes output register)

Function
REQ-003 Each entry SHALL hold: valid, opcode, tag, busy[2], Q[2], V[2].
REQ-004 o_dsp_ready SHALL be 1 iff at least one entry is invalid in current registered state (a slot freed this cycle is not reusable until next cycle).
REQ-005 Dispatch handshake: i_dsp_valid && o_dsp_ready at a rising edge SHALL write the lowest-index invalid entry and set it valid.
REQ-006 Dispatch bypass: if i_cdb_valid and i_cdb_tag equals a busy operand's Q in the same cycle, that operand SHALL be stored with V=i_cdb_wdata, busy=0.
REQ-007 Wake-up: each cycle with i_cdb_valid, every valid entry operand with busy=1 and Q==i_cdb_tag SHALL capture i_cdb_wdata and clear busy at that edge; non-matching operands unchanged.
REQ-008 An entry SHALL be ready iff valid and busy==2'b00 in registered state.
REQ-009 Output register (ORV, opcode, tag, V) SHALL drive o_iu_* directly; o_iu_valid = ORV.
REQ-010 Load condition: (!ORV || i_iu_ready) and at least one ready entry -> lowest-index ready entry copied into output register, that entry invalidated, ORV=1.
REQ-011 If ORV && i_iu_ready and no ready entry: ORV SHALL clear to 0.
REQ-012 While ORV && !i_iu_ready, all o_iu_* SHALL hold stable.
REQ-013 Minimum latency: dispatch with busy=00 accepted at edge E0 -> o_iu_valid=1 after E1.
REQ-014 CDB wake-up at edge E -> entry eligible for load at E+1 (registered ready).
REQ-015 Simultaneous dispatch, wake-up, load in one cycle SHALL all take effect; dispatched entry never loaded in its dispatch cycle.
REQ-016 Full (N_ENTRY valid): o_dsp_ready=0; i_dsp_valid ignored, no state change from dispatch.
REQ-017 o_count SHALL equal the number of valid entries, updated at each edge (+1 dispatch, -1 load, both -> unchanged).
REQ-018 CDB broadcasts SHALL never be backpressured; a tag matching no busy operand has no effect.

Reset
REQ-019 On rst_n=0 (asynchronous, any time incl. mid-operation): all entry valid=0, ORV=0, o_iu_opcode/o_iu_tag/o_iu_V_flatten=0, o_count=0; after release o_dsp_ready=1, o_iu_valid=0.
REQ-020 Instructions held at reset SHALL be discarded; none issued after release.

Verification
REQ-021 Dispatch ADD tag=2, busy=00, V0=5, V1=7, i_iu_ready=1 -> o_iu_valid=1 two edges later, opcode ADD, tag 2, V_flatten={7,5}.
REQ-022 Dispatch tag=1 busy=01 Q0=4; later CDB tag=4 data=0x10 -> one edge later load eligible, issued V0=0x10.
REQ-023 Dispatch busy=10 Q1=3 while CDB tag=3 data=9 same cycle -> entry stored ready, issued V1=9 with minimum latency.
REQ-024 Fill 4 entries with busy=11, i_iu_ready=0 -> o_dsp_ready=0, o_count=4, 5th dispatch ignored; hold o_iu_ready=0 after wake-ups -> o_iu_* stable.
REQ-025 Two entries (idx0, idx1) woken by one CDB -> idx0 issued first, idx1 next cycle with i_iu_ready=1.
REQ-026 Assert rst_n=0 with ORV=1 and 3 valid entries -> immediately o_iu_valid=0, o_count=0; after release no issue occurs.
